icache_fill_responder: RTL



---
 rtl/icache_fill_responder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/icache_fill_responder.sv
// Direct-mapped instruction cache with a two-state line-fill engine.
// Hits return the word combinationally; misses stall fetch while a full line streams in from main memory.
module icache_fill_responder #(
    parameter int WORDS_PER_LINE = 8,
    parameter int NUM_SETS       = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] fetch_addr,
    input  logic        fetch_en,
    input  logic        flush,
    output logic [15:0] instr,
    output logic        miss_stall,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rvalid
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 16 - 1 - OFF_W - IDX_W;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t state, state_nxt;

    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             addr_unused;

    assign off         = fetch_addr[OFF_W:1];
    assign idx         = fetch_addr[OFF_W+IDX_W:OFF_W+1];
    assign tag         = fetch_addr[15:OFF_W+IDX_W+1];
    assign addr_unused = fetch_addr[0];

    logic [NUM_SETS-1:0] valid;
    logic [TAG_W-1:0]    tag_arr  [NUM_SETS];
    logic [15:0]         data_arr [NUM_SETS][WORDS_PER_LINE];

    logic [15:0]      base_q;
    logic [IDX_W-1:0] idx_q;
    logic [TAG_W-1:0] tag_q;
    logic [OFF_W-1:0] issue_cnt;
    logic [OFF_W-1:0] recv_cnt;
    logic             issue_done;
    logic             discard;

    logic hit;
    logic fill_start;
    logic fill_last;

    assign hit = fetch_en && (state == IDLE) && valid[idx] && (tag_arr[idx] == tag);

    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    always_comb begin
        state_nxt  = state;
        miss_stall = fetch_en && !hit;
        instr      = hit ? data_arr[idx][off] : 16'h0000;
        mem_rd     = 1'b0;
        mem_addr   = 16'h0000;
        fill_start = 1'b0;
        fill_last  = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_en && !hit) begin
                    state_nxt  = FILL;
                    fill_start = 1'b1;
                end
            end
            FILL: begin
                mem_rd = !issue_done;
                if (!issue_done) begin
                    mem_addr = base_q + 16'({issue_cnt, 1'b0});
                end
                if (mem_rvalid && (recv_cnt == LAST_WORD)) begin
                    fill_last = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid      <= '0;
            base_q     <= 16'h0000;
            idx_q      <= '0;
            tag_q      <= '0;
            issue_cnt  <= '0;
            recv_cnt   <= '0;
            issue_done <= 1'b0;
            discard    <= 1'b0;
        end else begin
            if (fill_start) begin
                base_q     <= {fetch_addr[15:OFF_W+1], {(OFF_W+1){1'b0}}};
                idx_q      <= idx;
                tag_q      <= tag;
                issue_cnt  <= '0;
                recv_cnt   <= '0;
                issue_done <= 1'b0;
                discard    <= 1'b0;
            end
            if (state == FILL) begin
                if (!issue_done) begin
                    issue_cnt <= issue_cnt + 1'b1;
                    if (issue_cnt == LAST_WORD) begin
                        issue_done <= 1'b1;
                    end
                end
                if (mem_rvalid) begin
                    recv_cnt <= recv_cnt + 1'b1;
                end
                if (flush) begin
                    discard <= 1'b1;
                end
            end
            // Flush wins over the miss invalidation; a flush on the final fill edge still discards.
            if (flush) begin
                valid <= '0;
            end else if (fill_start) begin
                valid[idx] <= 1'b0;
            end
            if (fill_last) begin
                valid[idx_q] <= !(discard || flush);
            end
        end
    end

    // NOTE: tag and data storage carry no reset; the valid bits alone decide whether they are trusted.
    always_ff @(posedge clk) begin
        if ((state == FILL) && mem_rvalid) begin
            data_arr[idx_q][recv_cnt] <= mem_rdata;
        end
        if (fill_last) begin
            tag_arr[idx_q] <= tag_q;
        end
    end

endmodule
